// File: rtl/core_pkg.sv
// Shared types and constants for the fetch front end of the core.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between the memory bus and ID: push/pop/flush with a
// combinational head view. Flush overrides any same-cycle push or pop.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn_i,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_entry,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign do_push = push && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding req/gnt/rvalid fetcher feeding a
// small FIFO toward ID, with redirect-driven flush and response discard.
module if_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        notify_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_t     state_reg;
    logic [31:0]      pc_reg;
    logic             redirect_pending_reg;
    logic [31:0]      redirect_target;
    logic             fifo_push;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     fifo_head;
    fetch_entry_t     push_entry;

    assign redirect_target = redirect_pc_i & ~32'h3;
    // The held request address is the PC of the word coming back.
    assign fifo_push       = (state_reg == WAIT) && imem_rvalid_i && !redirect_i;
    assign push_entry      = '{instr: imem_rdata_i, pc: imem_addr_o};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fetch_fifo (
        .clk        (clk),
        .resetn_i   (resetn_i),
        .push       (fifo_push),
        .pop        (notify_i),
        .flush      (redirect_i),
        .push_entry (push_entry),
        .head       (fifo_head),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );

    assign valid_o = !fifo_empty;
    assign instr_o = fifo_head.instr;
    assign pc_o    = fifo_head.pc;

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_reg            <= IDLE;
            pc_reg               <= RESET_PC;
            imem_req_o           <= 1'b0;
            imem_addr_o          <= RESET_PC;
            redirect_pending_reg <= 1'b0;
        end else begin
            if (redirect_i) begin
                pc_reg <= redirect_target;
            end
            unique case (state_reg)
                IDLE: begin
                    if (fifo_count < CNT_W'(FIFO_DEPTH) && !redirect_i) begin
                        state_reg   <= REQ;
                        imem_req_o  <= 1'b1;
                        imem_addr_o <= pc_reg;
                    end
                end
                REQ: begin
                    if (imem_gnt_i) begin
                        imem_req_o           <= 1'b0;
                        redirect_pending_reg <= 1'b0;
                        // A pending redirect already loaded pc_reg with the target.
                        if (!redirect_i && !redirect_pending_reg) begin
                            pc_reg <= pc_reg + INSTR_BYTES;
                        end
                        state_reg <= (redirect_i || redirect_pending_reg) ? DISCARD : WAIT;
                    end else if (redirect_i) begin
                        redirect_pending_reg <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state_reg <= IDLE;
                    end else if (redirect_i) begin
                        state_reg <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_rvalid_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
